// File: rtl/rtc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rtc_pkg                                                       |
// | Purpose  : Shared definitions for the RTC read-transaction engine:       |
// |            register-index to RTC-address map, phase window constants,    |
// |            FSM state encoding and shadow-bank depth.                     |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package rtc_pkg;

  // Number of shadow registers (indices 0..N_REG-1).
  localparam int N_REG = 9;

  // RTC address for each register index. Time fields live at 0x21..0x26,
  // date fields at 0x41..0x43.
  localparam logic [0:8][7:0] RTC_ADDR = '{
    8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43
  };

  // Phase windows inside one 181-cycle upstream period.
  localparam logic [7:0] PH_START    = 8'd2;   // IDLE -> ADDR, address latched
  localparam logic [7:0] PH_CS_A_ON  = 8'd3;   // chip select low, address cycle
  localparam logic [7:0] PH_WR_ON    = 8'd4;   // address strobe low
  localparam logic [7:0] PH_CS_A_OFF = 8'd8;   // last phase with cs low (wr ends one earlier)
  localparam logic [7:0] PH_GAP      = 8'd10;  // ADDR -> GAP, bus released
  localparam logic [7:0] PH_READ     = 8'd20;  // GAP -> READ
  localparam logic [7:0] PH_CS_R_ON  = 8'd21;  // chip select low, data cycle
  localparam logic [7:0] PH_RD_ON    = 8'd22;  // read strobe low
  localparam logic [7:0] PH_RD_OFF   = 8'd27;  // last phase with rd low
  localparam logic [7:0] PH_CS_R_OFF = 8'd28;  // last phase with cs low
  localparam logic [7:0] PH_HOLD     = 8'd30;  // READ -> HOLD

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_GAP  = 3'd2,
    ST_READ = 3'd3,
    ST_HOLD = 3'd4
  } rtc_state_e;

  // Register index to RTC address; invalid indices map to 0x00.
  function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
    logic [7:0] addr;
    addr = 8'h00;
    case (idx)
      4'd0:    addr = RTC_ADDR[0];
      4'd1:    addr = RTC_ADDR[1];
      4'd2:    addr = RTC_ADDR[2];
      4'd3:    addr = RTC_ADDR[3];
      4'd4:    addr = RTC_ADDR[4];
      4'd5:    addr = RTC_ADDR[5];
      4'd6:    addr = RTC_ADDR[6];
      4'd7:    addr = RTC_ADDR[7];
      4'd8:    addr = RTC_ADDR[8];
      default: addr = 8'h00;
    endcase
    return addr;
  endfunction

endpackage : rtc_pkg
`default_nettype wire

// File: rtl/banco_reg_rtc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : banco_reg_rtc                                                 |
// | Purpose  : Shadow register bank holding the raw (BCD) bytes read from    |
// |            the RTC. One synchronous write port, one combinational read   |
// |            port returning 0x00 for out-of-range indices.                 |
// | Ports    : clk, reset      clock / async active-high reset              |
// |            we_i, wa_i, wd_i write enable, index, data                   |
// |            ra_i, rd_o       read index, read data (combinational)        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module banco_reg_rtc
  import rtc_pkg::*;
#(
  parameter int DEPTH = N_REG
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we_i,
  input  logic [3:0] wa_i,
  input  logic [7:0] wd_i,
  input  logic [3:0] ra_i,
  output logic [7:0] rd_o
);

  localparam logic [3:0] LAST_IDX = 4'(DEPTH - 1);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (we_i && (wa_i <= LAST_IDX)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd_o = 8'h00;
    if (ra_i <= LAST_IDX) begin
      rd_o = mem_q[ra_i];
    end
  end

endmodule : banco_reg_rtc
`default_nettype wire

// File: rtl/lectura_bus_rtc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lectura_bus_rtc                                               |
// | Purpose  : Read-transaction engine for the multiplexed RTC bus. For each |
// |            register index supplied by the read-sequence counter it runs  |
// |            one address cycle and one data cycle, captures the returned   |
// |            byte into the shadow bank and flags completed frames.         |
// | Ports    : clk, reset        clock / async active-high reset             |
// |            en_i              read-mode enable                             |
// |            fase_i, dir_i     phase count and register index (upstream)   |
// |            ad_in_i           bus data returned by the RTC                |
// |            ad_out_o, ad_oe_o bus drive value / drive enable              |
// |            a_d_o             0 = address cycle, 1 = data cycle           |
// |            cs_n_o, rd_n_o,   chip select, read strobe, address strobe    |
// |            wr_n_o            (all active-low)                            |
// |            sel_i, dato_sel_o bank read index / data                      |
// |            trama_ok_o        one-cycle pulse after bank[8] is written    |
// |            valido_o          sticky: a full frame has been captured      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module lectura_bus_rtc #(
  parameter int N_REG = rtc_pkg::N_REG,
  parameter int T_CAP = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [7:0] fase_i,
  input  logic [3:0] dir_i,
  input  logic [7:0] ad_in_i,
  output logic [7:0] ad_out_o,
  output logic       ad_oe_o,
  output logic       a_d_o,
  output logic       cs_n_o,
  output logic       rd_n_o,
  output logic       wr_n_o,
  input  logic [3:0] sel_i,
  output logic [7:0] dato_sel_o,
  output logic       trama_ok_o,
  output logic       valido_o
);

  import rtc_pkg::*;

  localparam logic [3:0] LAST_IDX  = 4'(N_REG - 1);
  localparam logic [7:0] PH_SAMPLE = 8'(T_CAP);

  rtc_state_e state_q, state_d;

  logic [7:0] ad_out_q,   ad_out_d;
  logic       ad_oe_q,    ad_oe_d;
  logic       a_d_q,      a_d_d;
  logic       cs_n_q,     cs_n_d;
  logic       rd_n_q,     rd_n_d;
  logic       wr_n_q,     wr_n_d;
  logic       trama_ok_q, trama_ok_d;
  logic       valido_q,   valido_d;

  logic       dir_ok;
  logic       capture;

  assign dir_ok = (dir_i <= LAST_IDX);

  // Capture uses the index present at the sampling edge. Dropping en or an
  // invalid index at that edge suppresses the write.
  assign capture = en_i && (state_q == ST_READ) && (fase_i == PH_SAMPLE) && dir_ok;

  // -------------------------------------------------------------------------
  // Next state and next registered outputs. Outputs are derived from the
  // state being entered together with the phase at this edge, so each bus
  // signal changes exactly one clock after its qualifying phase value.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ad_out_d   = 8'h00;
    ad_oe_d    = 1'b0;
    a_d_d      = 1'b1;
    cs_n_d     = 1'b1;
    rd_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    trama_ok_d = 1'b0;
    valido_d   = valido_q;

    if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((fase_i == PH_START) && dir_ok) begin
            state_d = ST_ADDR;
          end
        end
        // In each active state any phase outside the expected run aborts
        // the transaction back to IDLE without a capture.
        ST_ADDR: begin
          if (fase_i == PH_GAP) begin
            state_d = ST_GAP;
          end else if (!((fase_i > PH_START) && (fase_i < PH_GAP))) begin
            state_d = ST_IDLE;
          end
        end
        ST_GAP: begin
          if (fase_i == PH_READ) begin
            state_d = ST_READ;
          end else if (!((fase_i > PH_GAP) && (fase_i < PH_READ))) begin
            state_d = ST_IDLE;
          end
        end
        ST_READ: begin
          if (fase_i == PH_HOLD) begin
            state_d = ST_HOLD;
          end else if (!((fase_i > PH_READ) && (fase_i < PH_HOLD))) begin
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          // Wrap of the period (phase 0) or any step backwards ends HOLD.
          if (fase_i <= PH_HOLD) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    case (state_d)
      ST_ADDR: begin
        a_d_d   = 1'b0;
        ad_oe_d = 1'b1;
        // Latch the address on entry and hold it for the whole address cycle.
        ad_out_d = (state_q == ST_IDLE) ? rtc_addr(dir_i) : ad_out_q;
        cs_n_d  = !((fase_i >= PH_CS_A_ON) && (fase_i <= PH_CS_A_OFF));
        wr_n_d  = !((fase_i >= PH_WR_ON) && (fase_i < PH_CS_A_OFF));
      end
      ST_GAP: begin
        // Bus released, still nominally in the address half.
        a_d_d = 1'b0;
      end
      ST_READ: begin
        cs_n_d = !((fase_i >= PH_CS_R_ON) && (fase_i <= PH_CS_R_OFF));
        rd_n_d = !((fase_i >= PH_RD_ON) && (fase_i <= PH_RD_OFF));
      end
      default: begin
      end
    endcase

    if (capture && (dir_i == LAST_IDX)) begin
      trama_ok_d = 1'b1;
      valido_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ad_out_q   <= 8'h00;
      ad_oe_q    <= 1'b0;
      a_d_q      <= 1'b1;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      trama_ok_q <= 1'b0;
      valido_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ad_out_q   <= ad_out_d;
      ad_oe_q    <= ad_oe_d;
      a_d_q      <= a_d_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      trama_ok_q <= trama_ok_d;
      valido_q   <= valido_d;
    end
  end

  banco_reg_rtc #(
    .DEPTH (N_REG)
  ) u_banco (
    .clk   (clk),
    .reset (reset),
    .we_i  (capture),
    .wa_i  (dir_i),
    .wd_i  (ad_in_i),
    .ra_i  (sel_i),
    .rd_o  (dato_sel_o)
  );

  assign ad_out_o   = ad_out_q;
  assign ad_oe_o    = ad_oe_q;
  assign a_d_o      = a_d_q;
  assign cs_n_o     = cs_n_q;
  assign rd_n_o     = rd_n_q;
  assign wr_n_o     = wr_n_q;
  assign trama_ok_o = trama_ok_q;
  assign valido_o   = valido_q;

endmodule : lectura_bus_rtc
`default_nettype wire

// File: tb/tb_lectura_bus_rtc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lectura_bus_rtc                                            |
// | Purpose  : Self-checking bench for lectura_bus_rtc. Drives whole         |
// |            181-phase periods and compares every cycle against a phase-   |
// |            window model of the bus protocol and a shadow-bank array.     |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_lectura_bus_rtc;

  localparam int T_CAP  = 27;
  localparam int NO_EVT = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_i;
  logic [7:0] fase_i;
  logic [3:0] dir_i;
  logic [7:0] ad_in_i;
  logic [3:0] sel_i;
  logic [7:0] ad_out_o;
  logic       ad_oe_o;
  logic       a_d_o;
  logic       cs_n_o;
  logic       rd_n_o;
  logic       wr_n_o;
  logic [7:0] dato_sel_o;
  logic       trama_ok_o;
  logic       valido_o;

  always #5 clk = ~clk;

  lectura_bus_rtc #(
    .N_REG (9),
    .T_CAP (T_CAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en_i       (en_i),
    .fase_i     (fase_i),
    .dir_i      (dir_i),
    .ad_in_i    (ad_in_i),
    .ad_out_o   (ad_out_o),
    .ad_oe_o    (ad_oe_o),
    .a_d_o      (a_d_o),
    .cs_n_o     (cs_n_o),
    .rd_n_o     (rd_n_o),
    .wr_n_o     (wr_n_o),
    .sel_i      (sel_i),
    .dato_sel_o (dato_sel_o),
    .trama_ok_o (trama_ok_o),
    .valido_o   (valido_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] addr_tab [9];
  logic [7:0] mdl_bank [9];
  logic       mdl_txn;     // a valid transaction was started this period and not aborted
  logic       mdl_trama;
  logic       mdl_valido;
  int         cnt_cs, cnt_wr, cnt_rd, cnt_trama, tot_trama;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) mdl_bank[i] = 8'h00;
    mdl_txn    = 1'b0;
    mdl_trama  = 1'b0;
    mdl_valido = 1'b0;
  endtask

  function automatic logic [7:0] mdl_read(input logic [3:0] s);
    return (s <= 4'd8) ? mdl_bank[s] : 8'h00;
  endfunction

  // Expected bus values after the edge at which phase f was presented.
  task automatic check_outputs(input logic [7:0] f, input logic [3:0] d);
    logic       e_cs, e_wr, e_rd, e_oe, e_ad;
    logic [7:0] e_out;
    bit         c_ad, c_out;
    e_cs = 1'b1; e_wr = 1'b1; e_rd = 1'b1; e_oe = 1'b0; e_ad = 1'b1; e_out = 8'h00;
    c_ad = 1'b1; c_out = 1'b1;
    if (mdl_txn && (d <= 4'd8)) begin
      if ((f >= 8'd2) && (f <= 8'd9)) begin
        e_ad  = 1'b0;
        e_oe  = 1'b1;
        e_out = addr_tab[d];
        e_cs  = !((f >= 8'd3) && (f <= 8'd8));
        e_wr  = !((f >= 8'd4) && (f <= 8'd7));
      end else if ((f >= 8'd10) && (f <= 8'd19)) begin
        c_ad  = 1'b0;
        c_out = 1'b0;
      end else if ((f >= 8'd20) && (f <= 8'd29)) begin
        c_out = 1'b0;
        e_cs  = !((f >= 8'd21) && (f <= 8'd28));
        e_rd  = !((f >= 8'd22) && (f <= 8'd27));
      end
    end
    chk1("cs_n", cs_n_o, e_cs);
    chk1("wr_n", wr_n_o, e_wr);
    chk1("rd_n", rd_n_o, e_rd);
    chk1("ad_oe", ad_oe_o, e_oe);
    if (c_ad)  chk1("a_d", a_d_o, e_ad);
    if (c_out) chk8("ad_out", ad_out_o, e_out);
    chk1("trama_ok", trama_ok_o, mdl_trama);
    chk1("valido", valido_o, mdl_valido);
    chk8("dato_sel", dato_sel_o, mdl_read(sel_i));
    if (cs_n_o === 1'b0)     cnt_cs++;
    if (wr_n_o === 1'b0)     cnt_wr++;
    if (rd_n_o === 1'b0)     cnt_rd++;
    if (trama_ok_o === 1'b1) cnt_trama++;
  endtask

  // One clock with the given upstream values, then model update and checks.
  task automatic step(input logic [7:0] f, input logic [3:0] d, input logic e, input logic [7:0] a);
    fase_i  = f;
    dir_i   = d;
    en_i    = e;
    ad_in_i = a;
    sel_i   = 4'($urandom_range(0, 15));
    @(posedge clk);
    #1;
    mdl_trama = 1'b0;
    if (!e)             mdl_txn = 1'b0;
    else if (f == 8'd2) mdl_txn = (d <= 4'd8);
    if (mdl_txn && (f == 8'(T_CAP))) begin
      mdl_bank[d] = a;
      if (d == 4'd8) begin
        mdl_trama  = 1'b1;
        mdl_valido = 1'b1;
      end
    end
    check_outputs(f, d);
  endtask

  task automatic mid_reset(input logic [3:0] d);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs(fase_i, d);
    #1;
    reset = 1'b0;
  endtask

  // Full upstream period: phases 0..180 with optional en drop, forced
  // sample-phase data, and an asynchronous reset after phase rst_at.
  task automatic run_period(input logic [3:0] d, input int drop_at, input int drop_len,
                            input bit fix_cap, input logic [7:0] cap_val, input int rst_at);
    cnt_cs = 0; cnt_wr = 0; cnt_rd = 0; cnt_trama = 0;
    for (int f = 0; f <= 180; f++) begin
      logic       e;
      logic [7:0] a;
      e = !((f >= drop_at) && (f < drop_at + drop_len));
      a = (fix_cap && (f == T_CAP)) ? cap_val : 8'($urandom);
      step(8'(f), d, e, a);
      if (f == rst_at) mid_reset(d);
    end
  endtask

  task automatic sweep_bank(input string tag);
    for (int i = 0; i < 16; i++) begin
      sel_i = 4'(i);
      #1;
      chk8(tag, dato_sel_o, mdl_read(4'(i)));
    end
  endtask

  initial begin
    addr_tab = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    reset   = 1'b1;
    en_i    = 1'b0;
    fase_i  = 8'd0;
    dir_i   = 4'd0;
    ad_in_i = 8'h00;
    sel_i   = 4'd0;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_outputs(8'd0, 4'd0);
    sweep_bank("reset_bank");
    reset = 1'b0;

    // Reset while READ is active at phase 24: nothing captured afterwards
    run_period(4'd1, NO_EVT, 0, 1'b1, 8'h77, 24);
    sweep_bank("rst_read_bank");

    // Single read of index 1 returning 0x45
    run_period(4'd1, NO_EVT, 0, 1'b1, 8'h45, -1);
    chk_int("wr_n_low_cycles", cnt_wr, 4);
    chk_int("rd_n_low_cycles", cnt_rd, 6);
    chk_int("cs_n_low_cycles", cnt_cs, 14);
    sel_i = 4'd1;
    #1;
    chk8("sel1_after_read", dato_sel_o, 8'h45);

    // Full frame, data 0x10 + index
    tot_trama = 0;
    for (int d = 0; d <= 8; d++) begin
      run_period(4'(d), NO_EVT, 0, 1'b1, 8'(8'h10 + d), -1);
      tot_trama += cnt_trama;
    end
    chk_int("frame_trama_pulses", tot_trama, 1);
    chk1("frame_valido", valido_o, 1'b1);
    for (int i = 0; i <= 8; i++) begin
      sel_i = 4'(i);
      #1;
      chk8("frame_bank", dato_sel_o, 8'(8'h10 + i));
    end

    // en dropped at phase 25 on index 3: bank[3] keeps 0x13
    run_period(4'd3, 25, 3, 1'b1, 8'hAA, -1);
    chk_int("drop_trama_pulses", cnt_trama, 0);
    sel_i = 4'd3;
    #1;
    chk8("drop_bank3", dato_sel_o, 8'h13);

    // Invalid index 12: no chip select at all, bank untouched
    run_period(4'd12, NO_EVT, 0, 1'b1, 8'hEE, -1);
    chk_int("invalid_dir_cs_low", cnt_cs, 0);
    sweep_bank("invalid_dir_bank");

    // Bus data toggling every cycle: only the phase-27 byte is kept
    run_period(4'd5, NO_EVT, 0, 1'b1, 8'h5A, -1);
    sel_i = 4'd5;
    #1;
    chk8("toggle_bank5", dato_sel_o, 8'h5A);

    // Randomized periods with occasional en drops
    for (int k = 0; k < 14; k++) begin
      logic [3:0] d;
      int         drop;
      d    = 4'($urandom_range(0, 11));
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : NO_EVT;
      run_period(d, drop, int'($urandom_range(1, 4)), 1'b0, 8'h00, -1);
    end
    sweep_bank("random_bank");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_lectura_bus_rtc
`default_nettype wire

// File: doc/lectura_bus_rtc.md
# lectura_bus_rtc

Read-transaction engine for the RTC address/data-multiplexed bus. It consumes the phase count `fase` and register index `dir` produced by the read-sequence counter. For each index it executes one bus read: an address cycle followed by a data cycle. It captures the returned byte into a 9-entry shadow bank, which the display/formatting logic reads through a select port.

## Interface
Parameters:
- `N_REG`, 9: number of shadow registers; indices 0..8.
- `T_CAP`, 27: phase value at which read data is sampled.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `en`  in  1  read mode enable; same signal that drives the upstream counter
- `fase`  in  8  phase count from upstream, 0..180
- `dir`  in  4  register index from upstream, 0..8
- `ad_in`  in  8  data bus value returned by the RTC
- `ad_out`  out  8  value driven on the bus
- `ad_oe`  out  1  bus output enable; 1 means drive `ad_out`
- `a_d`  out  1  0 = address cycle, 1 = data cycle
- `cs_n`  out  1  chip select, active-low
- `rd_n`  out  1  read strobe, active-low
- `wr_n`  out  1  write/address strobe, active-low
- `sel`  in  4  bank read index
- `dato_sel`  out  8  bank[`sel`], combinational; 0 if `sel` > 8
- `trama_ok`  out  1  1-cycle pulse after bank[8] is written
- `valido`  out  1  sticky flag: at least one full frame captured since reset

## Operation
- Address map, `dir` to RTC address: 0→0x21, 1→0x22, 2→0x23, 3→0x24, 4→0x25, 5→0x26, 6→0x41, 7→0x42, 8→0x43.
- `dir` > 8 is invalid. No bus activity and no capture occur for it.
- The FSM has five states: IDLE, ADDR, GAP, READ, HOLD.
  - IDLE→ADDR: `en`=1, `fase`==2, `dir` valid. The address byte is latched at this edge.
  - ADDR→GAP: `fase`==10.
  - GAP→READ: `fase`==20.
  - READ→HOLD: `fase`==30.
  - HOLD→IDLE: `fase`==0.
- Bus outputs are registered. Each output takes the listed value after the rising edge at which the stated `fase` is present:
  - ADDR: `a_d`=0, `ad_oe`=1, `ad_out`=latched address.
    - `cs_n`=0 for `fase` 3..8.
    - `wr_n`=0 for `fase` 4..7.
  - GAP: all strobes high, `ad_oe`=0.
  - READ: `a_d`=1, `ad_oe`=0.
    - `cs_n`=0 for `fase` 21..28.
    - `rd_n`=0 for `fase` 22..27.
  - IDLE/HOLD: `cs_n`=`rd_n`=`wr_n`=1, `ad_oe`=0, `a_d`=1, `ad_out`=0.
- Capture: at the edge where state is READ and `fase`==`T_CAP`, bank[`dir`] ← `ad_in`. The byte is stored raw (BCD), with no conversion.
- When the captured index is 8, `trama_ok`=1 for the next cycle and `valido` is set.
- `en`=0 in any state: next edge goes to IDLE with bus idle values. A capture in progress is dropped. Bank contents and `valido` are kept.
- `fase` stepping out of the expected sequence (e.g. jumping to 0 mid-ADDR): return to IDLE at that edge with no capture.
- `dir` changing mid-transaction: the captured index is the `dir` present at the capture edge. Upstream changes `dir` only at `fase` 0→1, so this does not occur in normal use.

## Timing
- Reset values:
  - FSM: IDLE.
  - Bank: all bytes 0x00.
  - Outputs: `ad_out`=0, `ad_oe`=0, `a_d`=1, `cs_n`=`rd_n`=`wr_n`=1, `trama_ok`=0, `valido`=0.
- Every bus output has a latency of 1 clock from the qualifying `fase` value.
- A bank write is visible on `dato_sel` in the cycle after the capture edge.
- `trama_ok` is asserted in the same cycle that bank[8] becomes visible.
- Guard band: at least one cycle with `cs_n`=0 before and after each `wr_n`/`rd_n` low pulse. `ad_oe` is deasserted at least 10 cycles before `rd_n` falls.
- One transaction per `dir` per 181-cycle upstream period. A full frame takes 9 periods.

## Structure
- Shared package `rtc_pkg` holds:
  - the address-map constants `RTC_ADDR[0..8]`;
  - the phase window constants (2, 3, 4, 8, 10, 20, 21, 22, 27, 28, 30);
  - the FSM state encoding;
  - `N_REG`.
- Sub-module `banco_reg_rtc`: 9×8 register bank with async reset, one write port (`we`, `wa`, `wd`) and one combinational read port that returns 0 when the index is out of range.

## Test plan
- Reset mid-READ (`fase`=24): outputs go to reset values immediately. The bank is 0x00, and no capture occurs at a later `fase` 27 until a new ADDR phase.
- `en`=1, `dir`=1, `ad_in`=0x45:
  - 0x22 is driven with `ad_oe`=1 and `a_d`=0 during the address window; `wr_n` is low for exactly 4 cycles.
  - `rd_n` is low for 6 cycles.
  - `dato_sel` (`sel`=1) reads 0x45 after the capture.
- Full frame, `ad_in`=0x10+`dir`: after `dir` 8 completes, `trama_ok` pulses once and `valido`=1. `sel`=0..8 returns 0x10..0x18.
- `en` dropped at `fase`=25 with `dir`=3: next edge shows all strobes high and `ad_oe`=0. Bank[3] keeps its old value and `trama_ok` does not pulse.
- `dir` forced to 12: no `cs_n` assertion in the whole period, and the bank is unchanged.
- `ad_in` toggling except at `fase` 27: only the value present at `fase` 27 is stored.
